multi_alarm_unit: RTL and testbench

//  Parametrised N-channel alarm engine for the digital clock core; generalises the single alarm of main_driver.

---
 rtl/clock_pkg.sv | 28 ++
 rtl/alarm_channel.sv | 166 ++++++++++++++++
 rtl/multi_alarm_unit.sv | 135 +++++++++++++
 tb/tb_multi_alarm_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : clock_pkg                                                 |
// | Purpose  : Shared alarm state encoding and 24 h time limits for the  |
// |            digital clock alarm engine.                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_t;

  localparam logic [7:0] MAX_HOUR = 8'd23;
  localparam logic [7:0] MAX_MIN  = 8'd59;
  localparam logic [7:0] MAX_SEC  = 8'd59;

  // True when h:m:s is a legal time of day.
  function automatic logic time_valid(input logic [7:0] h,
                                      input logic [7:0] m,
                                      input logic [7:0] s);
    return (h <= MAX_HOUR) && (m <= MAX_MIN) && (s <= MAX_SEC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alarm_channel                                             |
// | Purpose  : One alarm channel: stored time/enable, ring/snooze/stop   |
// |            FSM, snooze counter, silence timer and ring timeout.      |
// |            ALARM_WEEKDAY_EN adds a weekday mask to the match.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module alarm_channel
  import clock_pkg::*;
#(
  parameter int SNOOZE_SEC   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
`ifdef ALARM_WEEKDAY_EN
  input  logic [2:0] cur_weekday,
  input  logic [6:0] wr_days,
`endif
  input  logic       wr_en,
  input  logic [7:0] wr_hour,
  input  logic [7:0] wr_min,
  input  logic [7:0] wr_sec,
  input  logic       wr_enable,
  input  logic       stop_hit,
  input  logic       snooze_hit,
  output logic       ringing,
  output logic       snoozed
);

  localparam logic [7:0] SNOOZE_LEN = 8'(SNOOZE_SEC);
  localparam logic [7:0] SNOOZE_LIM = 8'(MAX_SNOOZE);
  localparam logic [7:0] RING_LAST  = 8'(RING_TIMEOUT - 1);

  alarm_state_t state, state_nxt;
  logic [7:0]   alm_hour, alm_min, alm_sec;
  logic         alm_en;
  logic [7:0]   snooze_cnt, snooze_cnt_nxt;
  logic [7:0]   silence, silence_nxt;
  logic [7:0]   ring_timer, ring_timer_nxt;
  logic         day_ok;
  logic         match;
  logic         go_idle;

`ifdef ALARM_WEEKDAY_EN
  logic [6:0] alm_days;

  // Weekday gate: the selected mask bit must be set; weekday 7 never matches.
  always_comb begin
    day_ok = 1'b0;
    for (int d = 0; d < 7; d++) begin
      if (cur_weekday == 3'(d)) day_ok = alm_days[d];
    end
  end
`else
  assign day_ok = 1'b1;
`endif

  assign match = alm_en && tick_1hz && day_ok &&
                 (alm_hour == cur_hour) && (alm_min == cur_min) && (alm_sec == cur_sec);

  // Stored alarm configuration; only validated writes arrive on wr_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      alm_hour <= '0;
      alm_min  <= '0;
      alm_sec  <= '0;
      alm_en   <= 1'b0;
`ifdef ALARM_WEEKDAY_EN
      alm_days <= '0;
`endif
    end else if (wr_en) begin
      alm_hour <= wr_hour;
      alm_min  <= wr_min;
      alm_sec  <= wr_sec;
      alm_en   <= wr_enable;
`ifdef ALARM_WEEKDAY_EN
      alm_days <= wr_days;
`endif
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      snooze_cnt <= '0;
      silence    <= '0;
      ring_timer <= '0;
    end else begin
      state      <= state_nxt;
      snooze_cnt <= snooze_cnt_nxt;
      silence    <= silence_nxt;
      ring_timer <= ring_timer_nxt;
    end
  end

  // Next state: write > stop > snooze > timeout/silence expiry > match.
  // A RINGING/SNOOZED channel never looks at match, so a stop or snooze on
  // the matching tick cannot re-ring the channel in the same cycle.
  always_comb begin
    state_nxt      = state;
    snooze_cnt_nxt = snooze_cnt;
    silence_nxt    = silence;
    ring_timer_nxt = ring_timer;
    go_idle        = wr_en;
    if (!wr_en) begin
      case (state)
        ST_IDLE: begin
          if (match) begin
            state_nxt      = ST_RINGING;
            ring_timer_nxt = '0;
          end
        end
        ST_RINGING: begin
          if (stop_hit) begin
            go_idle = 1'b1;
          end else if (snooze_hit) begin
            if (snooze_cnt < SNOOZE_LIM) begin
              state_nxt      = ST_SNOOZED;
              snooze_cnt_nxt = snooze_cnt + 8'd1;
              silence_nxt    = SNOOZE_LEN;
            end else begin
              go_idle = 1'b1;
            end
          end else if (tick_1hz) begin
            if (ring_timer >= RING_LAST) go_idle = 1'b1;
            else ring_timer_nxt = ring_timer + 8'd1;
          end
        end
        ST_SNOOZED: begin
          if (stop_hit) begin
            go_idle = 1'b1;
          end else if (tick_1hz) begin
            if (silence <= 8'd1) begin
              state_nxt      = ST_RINGING;
              silence_nxt    = '0;
              ring_timer_nxt = '0;
            end else begin
              silence_nxt = silence - 8'd1;
            end
          end
        end
        default: go_idle = 1'b1;
      endcase
    end
    // Enable bit is kept on IDLE entry so the alarm recurs the next day.
    if (go_idle) begin
      state_nxt      = ST_IDLE;
      snooze_cnt_nxt = '0;
      silence_nxt    = '0;
      ring_timer_nxt = '0;
    end
  end

  assign ringing = (state == ST_RINGING);
  assign snoozed = (state == ST_SNOOZED);

endmodule
`default_nettype wire

// File: rtl/multi_alarm_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : multi_alarm_unit                                          |
// | Purpose  : N-channel alarm engine: write validation, snooze/stop     |
// |            edge detection, lowest-index priority, merged buzzer.     |
// |            Optional ALARM_WEEKDAY_EN adds weekday mask matching.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module multi_alarm_unit
  import clock_pkg::*;
#(
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_SEC   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60,
  // Derived; leave at default.
  parameter int IDX_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_1hz,
  input  logic [7:0]            current_24_hour,
  input  logic [7:0]            current_24_min,
  input  logic [7:0]            current_24_sec,
`ifdef ALARM_WEEKDAY_EN
  input  logic [2:0]            current_weekday,
  input  logic [6:0]            alarm_input_days,
`endif
  input  logic                  set_alarm,
  input  logic [IDX_W-1:0]      alarm_sel,
  input  logic [7:0]            alarm_input_hour,
  input  logic [7:0]            alarm_input_min,
  input  logic [7:0]            alarm_input_sec,
  input  logic                  alarm_enable_in,
  input  logic                  snooze_alarm,
  input  logic                  stop_alarm,
  output logic                  alarm_buzzer,
  output logic [IDX_W-1:0]      active_alarm,
  output logic [NUM_ALARMS-1:0] alarm_pending,
  output logic                  set_error
);

  logic                  snooze_q, stop_q;
  logic                  snooze_edge, stop_edge;
  logic                  sel_ok, write_ok;
  logic [NUM_ALARMS-1:0] ringing_v, snoozed_v;
  logic [NUM_ALARMS-1:0] wr_en_v, stop_hit_v, snooze_hit_v;
  logic                  any_ring, any_snz;
  logic [IDX_W-1:0]      ring_idx, snz_idx;

  // Previous levels of snooze/stop so a held button acts only once.
  always_ff @(posedge clk) begin
    if (reset) begin
      snooze_q <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      snooze_q <= snooze_alarm;
      stop_q   <= stop_alarm;
    end
  end

  assign snooze_edge = snooze_alarm & ~snooze_q;
  assign stop_edge   = stop_alarm & ~stop_q;

  assign sel_ok   = 32'(alarm_sel) < 32'(NUM_ALARMS);
  assign write_ok = set_alarm && sel_ok &&
                    time_valid(alarm_input_hour, alarm_input_min, alarm_input_sec);

  // One-cycle error pulse for a rejected write.
  always_ff @(posedge clk) begin
    if (reset) set_error <= 1'b0;
    else       set_error <= set_alarm && !write_ok;
  end

  // Lowest-index RINGING and lowest-index SNOOZED channel.
  always_comb begin
    any_ring = 1'b0;
    any_snz  = 1'b0;
    ring_idx = '0;
    snz_idx  = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ringing_v[i]) begin
        any_ring = 1'b1;
        ring_idx = IDX_W'(i);
      end
      if (snoozed_v[i]) begin
        any_snz = 1'b1;
        snz_idx = IDX_W'(i);
      end
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    // Stop goes to the active ringer, else to the lowest snoozed channel;
    // snooze only ever goes to the active ringer.
    assign wr_en_v[i]      = write_ok && (alarm_sel == IDX_W'(i));
    assign stop_hit_v[i]   = stop_edge &&
                             (any_ring ? (ring_idx == IDX_W'(i))
                                       : (any_snz && (snz_idx == IDX_W'(i))));
    assign snooze_hit_v[i] = snooze_edge && any_ring && (ring_idx == IDX_W'(i));

    alarm_channel #(
      .SNOOZE_SEC   (SNOOZE_SEC),
      .MAX_SNOOZE   (MAX_SNOOZE),
      .RING_TIMEOUT (RING_TIMEOUT)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick_1hz    (tick_1hz),
      .cur_hour    (current_24_hour),
      .cur_min     (current_24_min),
      .cur_sec     (current_24_sec),
`ifdef ALARM_WEEKDAY_EN
      .cur_weekday (current_weekday),
      .wr_days     (alarm_input_days),
`endif
      .wr_en       (wr_en_v[i]),
      .wr_hour     (alarm_input_hour),
      .wr_min      (alarm_input_min),
      .wr_sec      (alarm_input_sec),
      .wr_enable   (alarm_enable_in),
      .stop_hit    (stop_hit_v[i]),
      .snooze_hit  (snooze_hit_v[i]),
      .ringing     (ringing_v[i]),
      .snoozed     (snoozed_v[i])
    );
  end

  // Outputs decode channel state flops directly: one cycle after the event.
  assign alarm_buzzer  = any_ring;
  assign active_alarm  = ring_idx;
  assign alarm_pending = ringing_v | snoozed_v;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_multi_alarm_unit                                       |
// | Purpose  : Scoreboard bench for multi_alarm_unit (default params).   |
// |            Build with ALARM_WEEKDAY_EN to cover the weekday mask.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_multi_alarm_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [7:0] current_24_hour = '0, current_24_min = '0, current_24_sec = '0;
  logic [2:0] current_weekday = '0;
  logic [6:0] alarm_input_days = 7'h7F;
  logic       set_alarm = 1'b0;
  logic [1:0] alarm_sel = '0;
  logic [7:0] alarm_input_hour = '0, alarm_input_min = '0, alarm_input_sec = '0;
  logic       alarm_enable_in = 1'b0;
  logic       snooze_alarm = 1'b0;
  logic       stop_alarm = 1'b0;
  logic       alarm_buzzer;
  logic [1:0] active_alarm;
  logic [3:0] alarm_pending;
  logic       set_error;

  multi_alarm_unit u_dut (
    .clk              (clk),
    .reset            (reset),
    .tick_1hz         (tick_1hz),
    .current_24_hour  (current_24_hour),
    .current_24_min   (current_24_min),
    .current_24_sec   (current_24_sec),
`ifdef ALARM_WEEKDAY_EN
    .current_weekday  (current_weekday),
    .alarm_input_days (alarm_input_days),
`endif
    .set_alarm        (set_alarm),
    .alarm_sel        (alarm_sel),
    .alarm_input_hour (alarm_input_hour),
    .alarm_input_min  (alarm_input_min),
    .alarm_input_sec  (alarm_input_sec),
    .alarm_enable_in  (alarm_enable_in),
    .snooze_alarm     (snooze_alarm),
    .stop_alarm       (stop_alarm),
    .alarm_buzzer     (alarm_buzzer),
    .active_alarm     (active_alarm),
    .alarm_pending    (alarm_pending),
    .set_error        (set_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      nm;
    logic       buz;
    logic [1:0] act;
    logic [3:0] pend;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   now_s  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in this cycle at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc != cyc || alarm_buzzer !== e.buz || active_alarm !== e.act ||
            alarm_pending !== e.pend || set_error !== e.err) begin
          n_fail++;
          $display("FAIL %s: got buzzer=%b active=%0d pending=%b set_error=%b, expected buzzer=%b active=%0d pending=%b set_error=%b (cycle %0d, due %0d)",
                   e.nm, alarm_buzzer, active_alarm, alarm_pending, set_error,
                   e.buz, e.act, e.pend, e.err, cyc, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic buz, input logic [1:0] act,
                            input logic [3:0] pend, input logic err);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.buz = buz; e.act = act; e.pend = pend; e.err = err;
    sb.push_back(e);
  endtask

  task automatic tick();
    current_24_hour = 8'(now_s / 3600);
    current_24_min  = 8'((now_s / 60) % 60);
    current_24_sec  = 8'(now_s % 60);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    now_s++;
  endtask

  task automatic tick_until(input int t);
    while (now_s < t) tick();
  endtask

  task automatic write(input int sel, input int h, input int m, input int s,
                       input logic en, input logic [6:0] days);
    set_alarm = 1'b1; alarm_sel = 2'(sel);
    alarm_input_hour = 8'(h); alarm_input_min = 8'(m); alarm_input_sec = 8'(s);
    alarm_enable_in = en; alarm_input_days = days;
    step();
    set_alarm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_alarm = 1'b0; step();
    stop_alarm = 1'b1; step();
    stop_alarm = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze_alarm = 1'b0; step();
    snooze_alarm = 1'b1; step();
    snooze_alarm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    expect_out("reset state", 0, 0, 4'b0000, 0);
    step();
    reset = 1'b0;

    // Single alarm: match, three snoozes, fourth snooze stops.
    write(0, 0, 0, 7, 1, 7'h7F);  expect_out("set ch0 ok", 0, 0, 4'b0000, 0);
    tick_until(7);                expect_out("before match", 0, 0, 4'b0000, 0);
    tick();                       expect_out("ch0 rings", 1, 0, 4'b0001, 0);
    pulse_snooze();               expect_out("snooze 1", 0, 0, 4'b0001, 0);
    repeat (4) tick();            expect_out("silent 4 ticks", 0, 0, 4'b0001, 0);
    tick();                       expect_out("re-ring 5th tick", 1, 0, 4'b0001, 0);
    snooze_alarm = 1'b0; step();
    snooze_alarm = 1'b1; step();  expect_out("snooze 2", 0, 0, 4'b0001, 0);
    repeat (5) tick();            expect_out("re-ring snooze held", 1, 0, 4'b0001, 0);
    step();                       expect_out("held snooze acts once", 1, 0, 4'b0001, 0);
    snooze_alarm = 1'b0;
    pulse_snooze();               expect_out("snooze 3", 0, 0, 4'b0001, 0);
    repeat (5) tick();            expect_out("re-ring 3", 1, 0, 4'b0001, 0);
    pulse_snooze();               expect_out("4th snooze stops", 0, 0, 4'b0000, 0);

    // Two channels matching together.
    write(1, 0, 0, 30, 1, 7'h7F);
    write(2, 0, 0, 30, 1, 7'h7F);
    tick_until(30);
    tick();                       expect_out("ch1 ch2 ring", 1, 1, 4'b0110, 0);
    pulse_stop();                 expect_out("stop ch1", 1, 2, 4'b0100, 0);
    pulse_stop();                 expect_out("stop ch2", 0, 0, 4'b0000, 0);

    // Ring timeout.
    write(3, 0, 0, 45, 1, 7'h7F);
    tick_until(45);
    tick();                       expect_out("ch3 rings", 1, 3, 4'b1000, 0);
    repeat (59) tick();           expect_out("ringing after 59 ticks", 1, 3, 4'b1000, 0);
    tick();                       expect_out("timeout at 60th tick", 0, 0, 4'b0000, 0);

    // Invalid writes leave ch3 untouched.
    write(3, 24, 0, 45, 1, 7'h7F); expect_out("hour 24 error", 0, 0, 4'b0000, 1);
    step();                        expect_out("error one cycle", 0, 0, 4'b0000, 0);
    write(3, 0, 60, 45, 1, 7'h7F); expect_out("min 60 error", 0, 0, 4'b0000, 1);
    now_s = 45;
    tick();                        expect_out("next day rings", 1, 3, 4'b1000, 0);
    write(3, 0, 0, 50, 1, 7'h7F);  expect_out("set on ringing -> idle", 0, 0, 4'b0000, 0);

    // Reset while snoozed.
    tick_until(50);
    tick();                       expect_out("ch3 rings at 50", 1, 3, 4'b1000, 0);
    pulse_snooze();               expect_out("ch3 snoozed", 0, 0, 4'b1000, 0);
    reset = 1'b1; step();         expect_out("reset clears", 0, 0, 4'b0000, 0);
    reset = 1'b0;
    now_s = 50;
    tick();                       expect_out("ch3 disabled by reset", 0, 0, 4'b0000, 0);

    // Stop with nothing ringing targets lowest snoozed; snooze ignored.
    write(0, 0, 1, 0, 1, 7'h7F);
    write(1, 0, 1, 0, 1, 7'h7F);
    tick_until(60);
    tick();                       expect_out("ch0 ch1 ring", 1, 0, 4'b0011, 0);
    pulse_snooze();               expect_out("snooze ch0", 1, 1, 4'b0011, 0);
    pulse_snooze();               expect_out("snooze ch1", 0, 0, 4'b0011, 0);
    pulse_snooze();               expect_out("snooze ignored", 0, 0, 4'b0011, 0);
    pulse_stop();                 expect_out("stop lowest snoozed", 0, 0, 4'b0010, 0);
    repeat (5) tick();            expect_out("ch1 re-rings", 1, 1, 4'b0010, 0);
    pulse_stop();                 expect_out("stop ch1 final", 0, 0, 4'b0000, 0);

`ifdef ALARM_WEEKDAY_EN
    write(2, 0, 1, 10, 1, 7'h02);
    current_weekday = 3'd1;
    tick_until(70);
    tick();                       expect_out("weekday 1 fires", 1, 2, 4'b0100, 0);
    pulse_stop();                 expect_out("weekday stop", 0, 0, 4'b0000, 0);
    current_weekday = 3'd2;
    now_s = 70;
    tick();                       expect_out("weekday 2 silent", 0, 0, 4'b0000, 0);
    current_weekday = 3'd0;
`endif

    repeat (3) step();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d checks left unevaluated, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
